// File: rtl/cntr_pkg.sv
// rtl/cntr_pkg.sv - shared constants and types for the counter load controller
package cntr_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/cntr_load_ctrl.sv
// rtl/cntr_load_ctrl.sv - sequencer that loads, tracks and periodically reloads a 4-bit counter
module cntr_load_ctrl
    import cntr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_reload,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_d,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] term_q;
    logic             reload_q;
    logic [WIDTH-1:0] nxt;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = ~cfg_ready;

    // Shadow follows what the counter will hold next: a reload when ld is high, else +1.
    assign nxt = cnt_ld ? cnt_d : shadow + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_ld   <= 1'b0;
            cnt_d    <= '0;
            tick     <= 1'b0;
            err      <= 1'b0;
            shadow   <= '0;
            term_q   <= '0;
            reload_q <= MODE_ONESHOT;
        end else if (abort) begin
            state  <= ST_IDLE;
            cnt_ld <= 1'b0;
            tick   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        term_q   <= cfg_term;
                        reload_q <= cfg_reload;
                        cnt_d    <= cfg_start;
                        cnt_ld   <= 1'b1;
                        err      <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shadow <= cnt_d;
                    tick   <= (cnt_d == term_q);
                    cnt_ld <= (cnt_d == term_q) && (reload_q == MODE_RELOAD);
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q != shadow) begin
                        err <= 1'b1;
                    end
                    // One-shot finishes after its single tick; the counter is left free-running.
                    if (tick && (reload_q == MODE_ONESHOT)) begin
                        tick   <= 1'b0;
                        cnt_ld <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        shadow <= nxt;
                        tick   <= (nxt == term_q);
                        cnt_ld <= (nxt == term_q) && (reload_q == MODE_RELOAD);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt_ld <= 1'b0;
                    tick   <= 1'b0;
                end
            endcase
        end
    end

endmodule
